// File: rtl/lynx_tpg_pkg.sv
// Shared types, LFSR seed and packet field positions for the traffic pattern
// generator and its downstream sink decoder.
package lynx_tpg_pkg;

  typedef enum logic [1:0] {
    DEST_FIXED = 2'd0,
    DEST_RR    = 2'd1,
    DEST_RAND  = 2'd2
  } dest_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } tpg_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Packet layout, MSB first: {src, dst, id[7:0], seq}
  function automatic int src_lsb(input int width, input int aw);
    return width - aw;
  endfunction

  function automatic int dst_lsb(input int width, input int aw);
    return width - 2 * aw;
  endfunction

  function automatic int seq_w(input int width, input int aw);
    return width - 2 * aw - 8;
  endfunction

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, shifting toward bit 0
  function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/burst_tpg_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step whenever step is high.
import lynx_tpg_pkg::*;

module lfsr16 #(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = step ? lfsr16_step(lfsr_q) : lfsr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/burst_tpg.sv
// NoC traffic pattern generator: emits {src,dst,id,seq} packets on valid/ready.
// Define BURST_TPG_TRACE_EN to print every accepted packet in simulation.
import lynx_tpg_pkg::*;

module burst_tpg #(
  parameter int         WIDTH        = 32,
  parameter int         N            = 16,
  parameter int         N_ADDR_WIDTH = $clog2(N),
  parameter logic [7:0] ID           = 8'd0,
  parameter int         NODE         = 0,
  parameter int         NUM_PKTS     = 16,
  parameter int         GAP          = 0,
  parameter int         DEST_MODE    = 0,
  parameter int         FIXED_DST    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             done,
  output logic [15:0]      sent_count
);

  localparam int AW    = N_ADDR_WIDTH;
  localparam int SEQ_W = seq_w(WIDTH, AW);
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [AW-1:0] NODE_A = AW'(NODE);

  if (SEQ_W < 1) begin : g_bad_width
    $error("burst_tpg: WIDTH leaves no room for the sequence field");
  end

  tpg_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [15:0]      sent_count_q, sent_count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             xfer, last, lfsr_step;
  logic [15:0]      lfsr_state;
  logic [AW-1:0]    rr_dst, rand_r, rand_dst, dst_adv;

  lfsr16 #(.SEED(LFSR_SEED ^ {8'h00, ID})) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  function automatic logic [WIDTH-1:0] pack(input logic [AW-1:0] d, input logic [SEQ_W-1:0] s);
    return {NODE_A, d, ID, s};
  endfunction

  function automatic logic [AW-1:0] rr_inc(input logic [AW-1:0] d);
    return (int'(d) == N - 1) ? '0 : d + AW'(1);
  endfunction

  assign xfer = valid_q & ready_in;
  assign last = (NUM_PKTS != 0) && (int'(sent_count_q) + 1 == NUM_PKTS);

  // Next destination, sampled from the LFSR value it is about to step to
  always_comb begin
    rr_dst   = rr_inc(dst_q);
    if (rr_dst == NODE_A) rr_dst = rr_inc(rr_dst);
    rand_r   = AW'(lfsr16_step(lfsr_state));
    rand_dst = (int'(rand_r) < N) ? rand_r : AW'(int'(rand_r) - N);
    case (DEST_MODE)
      int'(DEST_RR):   dst_adv = rr_dst;
      int'(DEST_RAND): dst_adv = rand_dst;
      default:         dst_adv = dst_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    data_d       = data_q;
    done_d       = done_q;
    sent_count_d = sent_count_q;
    seq_d        = seq_q;
    dst_d        = dst_q;
    gap_d        = gap_q;
    lfsr_step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SEND;
          valid_d = 1'b1;
          data_d  = pack(dst_q, seq_q);
        end
      end
      SEND: begin
        if (xfer) begin
          seq_d        = seq_q + SEQ_W'(1);
          sent_count_d = (sent_count_q == 16'hFFFF) ? sent_count_q : sent_count_q + 16'd1;
          dst_d        = dst_adv;
          lfsr_step    = (DEST_MODE == int'(DEST_RAND));
          valid_d      = 1'b0;
          if (last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (!enable) begin
            state_d = IDLE;
          end else if (GAP == 0) begin
            valid_d = 1'b1;
            data_d  = pack(dst_adv, seq_d);
          end else begin
            state_d = WAIT;
            gap_d   = GAP_W'(GAP);
          end
        end
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (gap_q == GAP_W'(1)) begin
          state_d = SEND;
          valid_d = 1'b1;
          data_d  = pack(dst_q, seq_q);
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      data_q       <= '0;
      done_q       <= 1'b0;
      sent_count_q <= '0;
      seq_q        <= '0;
      dst_q        <= AW'(FIXED_DST);
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      done_q       <= done_d;
      sent_count_q <= sent_count_d;
      seq_q        <= seq_d;
      dst_q        <= dst_d;
      gap_q        <= gap_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign done       = done_q;
  assign sent_count = sent_count_q;

`ifdef BURST_TPG_TRACE_EN
  localparam int DST_LSB = dst_lsb(WIDTH, AW);
  always_ff @(posedge clk) begin
    if (!rst && xfer)
      $display("TPG=%0d; %0t; from=%0d; to=%0d; data=%0d;",
               ID, $time, NODE, data_q[DST_LSB +: AW], data_q[SEQ_W-1:0]);
  end
`endif

endmodule

// File: tb/tb_burst_tpg.sv
// Randomized scoreboard bench: three generator configurations (fixed, round-robin
// with gap and seq wrap, pseudo-random) checked against a transaction-level model.
module tb_burst_tpg;

  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int         W    = (g == 0) ? 32 : (g == 1) ? 16 : 24;
    localparam int         NN   = (g == 0) ? 16 : (g == 1) ? 4 : 12;
    localparam logic [7:0] IDV  = (g == 0) ? 8'd3 : (g == 1) ? 8'h7E : 8'hA5;
    localparam int         NODE = (g == 0) ? 5 : (g == 1) ? 2 : 7;
    localparam int         NP   = (g == 0) ? 4 : (g == 1) ? 20 : 0;
    localparam int         GP   = (g == 0) ? 0 : (g == 1) ? 3 : 0;
    localparam int         MD   = g;
    localparam int         FD   = (g == 0) ? 9 : (g == 1) ? 0 : 3;
    localparam int         AW   = $clog2(NN);
    localparam int         SW   = W - 2 * AW - 8;
    localparam int unsigned SEED = 32'h0000ACE1 ^ 32'(IDV);

    logic         en  = 1'b1;
    logic         rdy = 1'b0;
    logic [W-1:0] dout;
    logic         vout, dn;
    logic [15:0]  cnt;

    burst_tpg #(
      .WIDTH(W), .N(NN), .ID(IDV), .NODE(NODE), .NUM_PKTS(NP),
      .GAP(GP), .DEST_MODE(MD), .FIXED_DST(FD)
    ) dut (
      .clk(clk), .rst(rst), .enable(en), .data_out(dout), .valid_out(vout),
      .ready_in(rdy), .done(dn), .sent_count(cnt)
    );

    // Reference model: k = packets accepted since reset, gd = destination of packet k
    logic [W-1:0] exp_q[$];
    int           k = 0;
    int           gd = FD;
    int           m_wait = 0;
    int unsigned  lf = SEED;
    bit           m_valid = 1'b0, m_fin = 1'b0, m_zero = 1'b1;

    function automatic logic [W-1:0] pkt(input int kk, input int d);
      longint v;
      v = (longint'(NODE) << (W - AW)) | (longint'(d) << (W - 2 * AW)) |
          (longint'(IDV) << SW) | longint'(kk % (1 << SW));
      return W'(v);
    endfunction

    task automatic advance_dst();
      if (MD == 1) begin
        gd = (gd + 1) % NN;
        if (gd == NODE) gd = (gd + 1) % NN;
      end else if (MD == 2) begin
        lf = (lf >> 1) | (((lf ^ (lf >> 2) ^ (lf >> 3) ^ (lf >> 5)) & 1) << 15);
        gd = int'(lf % (1 << AW));
        if (gd >= NN) gd -= NN;
      end
    endtask

    task automatic offer();
      m_valid = 1'b1;
      exp_q.push_back(pkt(k, gd));
    endtask

    // Stimulus: enable mostly high with occasional drops, ready random with stall bursts
    initial begin
      int stall;
      stall = 0;
      forever begin
        @(posedge clk); #1;
        if ($urandom_range(0, 11) == 0) en = ($urandom_range(0, 4) != 0);
        if (stall > 0) begin
          rdy = 1'b0;
          stall--;
        end else if ($urandom_range(0, 39) == 0) begin
          rdy = 1'b0;
          stall = 4;
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
        end
      end
    end

    // Model: advance by one edge using the inputs that will be sampled at it
    initial forever begin
      @(negedge clk); #1;
      if (rst) begin
        k = 0; gd = FD; lf = SEED; m_wait = 0;
        m_valid = 1'b0; m_fin = 1'b0; m_zero = 1'b1;
        exp_q.delete();
      end else begin
        m_zero = 1'b0;
        if (!m_fin) begin
          if (m_valid) begin
            if (rdy) begin
              k++;
              advance_dst();
              m_valid = 1'b0;
              if (NP != 0 && k == NP) m_fin = 1'b1;
              else if (en && GP == 0) offer();
              else if (en) m_wait = GP;
            end
          end else if (m_wait > 0) begin
            if (!en) m_wait = 0;
            else if (m_wait == 1) begin
              m_wait = 0;
              offer();
            end else m_wait--;
          end else if (en) begin
            offer();
          end
        end
      end
    end

    // Monitor: compare outputs each cycle, pop the scoreboard on each accepted packet
    initial forever begin
      @(negedge clk);
      chk("valid_out", g, 64'(vout), 64'(m_valid));
      chk("done", g, 64'(dn), 64'(m_fin));
      chk("sent_count", g, 64'(cnt), 64'((k > 65535) ? 65535 : k));
      if (m_zero) chk("data_out_after_reset", g, 64'(dout), 64'd0);
      if (vout === 1'b1) begin
        chk("queue_depth", g, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          chk("data_out", g, 64'(dout), 64'(exp_q[0]));
          if (rdy && !rst) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      rst = (c == 1500) || ($urandom_range(0, 699) == 0);
    end
    @(negedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/burst_tpg.md
Name: burst_tpg

Overview:
- Traffic pattern generator at a NoC input port; the upstream counterpart of the per-node traffic sink.
- Emits packets tagged with source node, destination node, generator ID and a sequence counter, so the downstream sink can decode and trace them.
- Uses a valid/ready handshake and supports a configurable packet count, inter-packet gap and destination pattern.

Parameters:
- WIDTH, 32, packet width in bits.
- N, 16, number of NoC nodes.
- N_ADDR_WIDTH, $clog2(N), width of the node address field.
- ID, 8'd0, generator tag placed in the ID field.
- NODE, 0, router index this generator drives; placed in the src field.
- NUM_PKTS, 16, packets to send per run; 0 means unlimited.
- GAP, 0, idle cycles inserted after each accepted packet.
- DEST_MODE, 0, destination pattern: 0 fixed, 1 round-robin, 2 pseudo-random.
- FIXED_DST, 1, destination used in mode 0; first destination in mode 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- data_out  out  WIDTH  packet: {src, dst, id, seq}.
- valid_out  out  1  data_out holds a valid packet.
- ready_in  in  1  downstream accepts the packet this cycle.
- done  out  1  NUM_PKTS packets have been accepted.
- sent_count  out  16  number of packets accepted since reset; saturates at 16'hFFFF.

Behaviour:
- Field layout:
  - data_out[WIDTH-1 -: N_ADDR_WIDTH] = NODE.
  - Next N_ADDR_WIDTH bits = dst.
  - Next 8 bits = ID.
  - Low SEQ_W = WIDTH-2*N_ADDR_WIDTH-8 bits = seq.
  - Elaboration error if SEQ_W < 1.
- Reset values: valid_out=0, data_out=0, done=0, sent_count=0, seq=0, dst=FIXED_DST, LFSR=16'hACE1^{8'h00,ID}, state IDLE.
- All outputs are registered.
- Handshake:
  - A transfer occurs when valid_out & ready_in are both 1 at a rising edge.
  - While valid_out=1 and no transfer has occurred, data_out is held stable.
  - valid_out is never retracted before a transfer, even if enable drops.
- States:
  - IDLE: valid_out=0. If enable=1, go to SEND and load data_out with the current {NODE,dst,ID,seq}. valid_out rises one cycle after enable is sampled high.
  - SEND: valid_out=1. On transfer:
    - seq increments (wraps mod 2^SEQ_W); sent_count increments; dst advances.
    - If NUM_PKTS!=0 and this was packet NUM_PKTS, go to DONE.
    - Else if enable=0, go to IDLE.
    - Else if GAP=0, stay in SEND with the next packet presented the following cycle (back-to-back, one packet per cycle at full throughput).
    - Else go to WAIT and load the gap counter with GAP.
  - WAIT: valid_out=0; the counter decrements each cycle. At 1, go to SEND with the next packet. If enable=0 during WAIT, go to IDLE immediately.
  - DONE: valid_out=0, done=1. Held until rst; enable is ignored.
- Destination advance, applied on transfer only:
  - Mode 0: dst stays FIXED_DST.
  - Mode 1: dst = (dst+1) mod N. If the result equals NODE, skip once more.
  - Mode 2: LFSR steps once (x^16+x^14+x^13+x^11+1, Fibonacci). r = LFSR[N_ADDR_WIDTH-1:0]; dst = r if r<N, else r-N. Self-destination is allowed.
- Resuming: re-asserting enable after IDLE continues from the current seq, dst and sent count; there is no restart.
- rst mid-packet drops valid_out on the next edge; the partial run is discarded.

Optional Feature:
- Macro: BURST_TPG_TRACE_EN.
- Defined: simulation-only $display of each transfer as "TPG=ID; time; from=NODE; to=dst; data=seq;". Printed at the transfer edge, in the same field order the sink uses.
- Undefined: no display or file I/O code is elaborated; the RTL is otherwise identical.

Decomposition:
- Package lynx_tpg_pkg:
  - dest_mode_e enum (DEST_FIXED, DEST_RR, DEST_RAND).
  - tpg_state_e enum (IDLE, SEND, WAIT, DONE).
  - LFSR seed constant.
  - Field-position localparam functions shared with sink decoding.
- Sub-module lfsr16: step enable in, 16-bit state out, seed parameter.

Test Plan:
- Smoke: ID=3, NODE=5, FIXED_DST=9, mode 0, NUM_PKTS=4, GAP=0, ready_in=1, enable=1 → 4 consecutive valid cycles with data_out 0x5903_0000..0x5903_0003, then done=1 and sent_count=4.
- Backpressure: ready_in low for 5 cycles mid-packet → data_out and valid_out stable; seq advances only after ready_in=1.
- Gap: GAP=3, NUM_PKTS=3 → valid_out pulses are separated by exactly 3 low cycles; done rises after the third transfer.
- Round-robin: mode 1, NODE=2, FIXED_DST=0, N=4 → dst sequence 0,1,3,0,1,3.
- Enable drop: enable=0 while SEND is stalled → packet is still held until accepted, then IDLE. Re-enable → seq continues (next seq = 1 after the first accepted packet).
- Reset mid-run: rst during SEND with seq=7 → next cycle valid_out=0, seq=0, sent_count=0, done=0.
